// File: rtl/ibex_rvfi_trace_buf.sv
// Synthesisable RVFI trace buffer: circular record store with an optional PC trigger,
// stop-on-full or wrap-around mode, and a first-word-fall-through readout port.
module ibex_rvfi_trace_buf #(
    parameter int unsigned Depth      = 16,
    parameter bit          WrapMode   = 1'b0,
    parameter bit          TrigEnable = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         rvfi_valid_i,
    input  logic [31:0]                  rvfi_pc_rdata_i,
    input  logic [31:0]                  rvfi_insn_i,
    input  logic [4:0]                   rvfi_rd_addr_i,
    input  logic [31:0]                  rvfi_rd_wdata_i,
    input  logic                         rvfi_trap_i,
    input  logic                         rvfi_intr_i,
    input  logic                         arm_i,
    input  logic                         stop_i,
    input  logic                         clear_i,
    input  logic                         trig_en_i,
    input  logic [31:0]                  trig_pc_i,
    output logic                         rd_valid_o,
    input  logic                         rd_ready_i,
    output logic [31:0]                  rd_pc_o,
    output logic [31:0]                  rd_insn_o,
    output logic [31:0]                  rd_wdata_o,
    output logic [4:0]                   rd_addr_o,
    output logic [1:0]                   rd_flags_o,
    output logic [$clog2(Depth+1)-1:0]   count_o,
    output logic [15:0]                  dropped_o,
    output logic [1:0]                   state_o
);

    localparam int unsigned PW = $clog2(Depth);
    localparam int unsigned CW = $clog2(Depth + 1);
    localparam logic [CW-1:0] FullCnt = CW'(Depth);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] wdata;
        logic [4:0]  addr;
        logic [1:0]  flags;
    } rec_t;

    state_e          state_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [15:0]     dropped_q;
    rec_t            mem_q [Depth];

    rec_t            wr_rec;
    rec_t            head;
    logic            trig_hit;
    logic            wr_req;
    logic            full;
    logic            pop;
    logic            drop;
    logic            do_store;
    logic            rd_adv;

    assign wr_rec = '{
        pc:    rvfi_pc_rdata_i,
        insn:  rvfi_insn_i,
        wdata: rvfi_rd_wdata_i,
        addr:  rvfi_rd_addr_i,
        flags: {rvfi_trap_i, rvfi_intr_i}
    };

    // The matching retirement is itself the first captured record.
    assign trig_hit = TrigEnable && (state_q == ARMED) && rvfi_valid_i
                      && (rvfi_pc_rdata_i == trig_pc_i);

    // A retirement coinciding with stop or clear is never stored.
    assign wr_req = rvfi_valid_i && !clear_i && !stop_i
                    && ((state_q == CAPTURE) || trig_hit);

    assign full     = (count_q == FullCnt);
    assign pop      = rd_valid_o && rd_ready_i && !clear_i;
    assign drop     = wr_req && full && !pop;
    assign do_store = wr_req && (!full || pop || WrapMode);
    assign rd_adv   = pop || (drop && WrapMode);

    assign head       = mem_q[rd_ptr_q];
    assign rd_valid_o = (count_q != '0);
    assign rd_pc_o    = head.pc;
    assign rd_insn_o  = head.insn;
    assign rd_wdata_o = head.wdata;
    assign rd_addr_o  = head.addr;
    assign rd_flags_o = head.flags;
    assign count_o    = count_q;
    assign dropped_o  = dropped_q;
    assign state_o    = state_q;

    // Session control: clear beats stop, stop beats arm.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else if (clear_i) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!stop_i && arm_i) begin
                        state_q <= (TrigEnable && trig_en_i) ? ARMED : CAPTURE;
                    end
                end
                ARMED: begin
                    if (stop_i) begin
                        state_q <= IDLE;
                    end else if (trig_hit) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (stop_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Pointers, occupancy and the saturating drop counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            dropped_q <= '0;
        end else if (clear_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            dropped_q <= '0;
        end else begin
            if (do_store) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (rd_adv) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (do_store && !pop && !full) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !wr_req) begin
                count_q <= count_q - CW'(1);
            end
            if (drop && (dropped_q != 16'hFFFF)) begin
                dropped_q <= dropped_q + 16'd1;
            end
        end
    end

    // Record storage; reset so the read port shows zeros before any capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_store) begin
            mem_q[wr_ptr_q] <= wr_rec;
        end
    end

endmodule

// File: tb/tb_ibex_rvfi_trace_buf.sv
// Bench for ibex_rvfi_trace_buf: stop-on-full and wrap instances (Depth=4) driven
// side by side and compared against a queue-based model of the capture rules.
module tb_ibex_rvfi_trace_buf;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] wdata;
        logic [4:0]  addr;
        logic [1:0]  flags;
    } rec_t;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] wdata;
    logic        trap;
    logic        intr;
    logic        arm;
    logic        stop;
    logic        clear;
    logic        trig_en;
    logic [31:0] trig_pc;
    logic        rd_ready;

    logic        o_valid [2];
    logic [31:0] o_pc    [2];
    logic [31:0] o_insn  [2];
    logic [31:0] o_wdata [2];
    logic [4:0]  o_addr  [2];
    logic [1:0]  o_flags [2];
    logic [2:0]  o_count [2];
    logic [15:0] o_drop  [2];
    logic [1:0]  o_state [2];

    rec_t mq [2][$];
    int   mst   [2];
    int   mdrop [2];

    int checks;
    int failures;

    ibex_rvfi_trace_buf #(.Depth(DEPTH), .WrapMode(1'b0), .TrigEnable(1'b1)) u_stop (
        .clk_i(clk), .rst_ni(rst_n),
        .rvfi_valid_i(valid), .rvfi_pc_rdata_i(pc), .rvfi_insn_i(insn),
        .rvfi_rd_addr_i(rd_addr), .rvfi_rd_wdata_i(wdata),
        .rvfi_trap_i(trap), .rvfi_intr_i(intr),
        .arm_i(arm), .stop_i(stop), .clear_i(clear),
        .trig_en_i(trig_en), .trig_pc_i(trig_pc),
        .rd_valid_o(o_valid[0]), .rd_ready_i(rd_ready),
        .rd_pc_o(o_pc[0]), .rd_insn_o(o_insn[0]), .rd_wdata_o(o_wdata[0]),
        .rd_addr_o(o_addr[0]), .rd_flags_o(o_flags[0]),
        .count_o(o_count[0]), .dropped_o(o_drop[0]), .state_o(o_state[0])
    );

    ibex_rvfi_trace_buf #(.Depth(DEPTH), .WrapMode(1'b1), .TrigEnable(1'b1)) u_wrap (
        .clk_i(clk), .rst_ni(rst_n),
        .rvfi_valid_i(valid), .rvfi_pc_rdata_i(pc), .rvfi_insn_i(insn),
        .rvfi_rd_addr_i(rd_addr), .rvfi_rd_wdata_i(wdata),
        .rvfi_trap_i(trap), .rvfi_intr_i(intr),
        .arm_i(arm), .stop_i(stop), .clear_i(clear),
        .trig_en_i(trig_en), .trig_pc_i(trig_pc),
        .rd_valid_o(o_valid[1]), .rd_ready_i(rd_ready),
        .rd_pc_o(o_pc[1]), .rd_insn_o(o_insn[1]), .rd_wdata_o(o_wdata[1]),
        .rd_addr_o(o_addr[1]), .rd_flags_o(o_flags[1]),
        .count_o(o_count[1]), .dropped_o(o_drop[1]), .state_o(o_state[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mq[m].delete();
            mst[m]   = 0;
            mdrop[m] = 0;
        end
    endtask

    // Apply one clock edge's worth of capture rules to each model.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            bit   do_pop;
            bit   do_wr;
            rec_t r;
            r = '{pc: pc, insn: insn, wdata: wdata, addr: rd_addr, flags: {trap, intr}};
            if (clear) begin
                mq[m].delete();
                mdrop[m] = 0;
                mst[m]   = 0;
            end else begin
                do_pop = (mq[m].size() != 0) && rd_ready;
                do_wr  = valid && !stop
                         && (mst[m] == 2 || (mst[m] == 1 && pc == trig_pc));
                if (do_pop) void'(mq[m].pop_front());
                if (do_wr) begin
                    if (mq[m].size() < DEPTH) begin
                        mq[m].push_back(r);
                    end else begin
                        if (mdrop[m] < 65535) mdrop[m]++;
                        if (m == 1) begin
                            void'(mq[m].pop_front());
                            mq[m].push_back(r);
                        end
                    end
                end
                if (stop) begin
                    mst[m] = 0;
                end else if (mst[m] == 0 && arm) begin
                    mst[m] = trig_en ? 1 : 2;
                end else if (mst[m] == 1 && valid && pc == trig_pc) begin
                    mst[m] = 2;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("state%0d", m), 32'(o_state[m]), 32'(mst[m]));
            chk($sformatf("count%0d", m), 32'(o_count[m]), 32'(mq[m].size()));
            chk($sformatf("drop%0d", m), 32'(o_drop[m]), 32'(mdrop[m]));
            chk($sformatf("rvalid%0d", m), 32'(o_valid[m]), 32'(mq[m].size() != 0));
            if (mq[m].size() != 0) begin
                chk($sformatf("rpc%0d", m), o_pc[m], mq[m][0].pc);
                chk($sformatf("rinsn%0d", m), o_insn[m], mq[m][0].insn);
                chk($sformatf("rwdata%0d", m), o_wdata[m], mq[m][0].wdata);
                chk($sformatf("raddr%0d", m), 32'(o_addr[m]), 32'(mq[m][0].addr));
                chk($sformatf("rflags%0d", m), 32'(o_flags[m]), 32'(mq[m][0].flags));
            end
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic pulse(input bit a, input bit s, input bit c);
        arm = a; stop = s; clear = c;
        cyc();
        arm = 1'b0; stop = 1'b0; clear = 1'b0;
    endtask

    task automatic retire(input logic [31:0] p);
        valid   = 1'b1;
        pc      = p;
        insn    = $urandom;
        wdata   = $urandom;
        rd_addr = 5'($urandom);
        trap    = 1'($urandom);
        intr    = 1'($urandom);
        cyc();
        valid = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; valid = 1'b0; pc = '0; insn = '0; rd_addr = '0;
        wdata = '0; trap = 1'b0; intr = 1'b0; arm = 1'b0; stop = 1'b0;
        clear = 1'b0; trig_en = 1'b0; trig_pc = '0; rd_ready = 1'b0;
        model_reset();

        // Reset values
        #12;
        for (int m = 0; m < 2; m++) begin
            chk("rst_state", 32'(o_state[m]), 32'd0);
            chk("rst_count", 32'(o_count[m]), 32'd0);
            chk("rst_drop", 32'(o_drop[m]), 32'd0);
            chk("rst_valid", 32'(o_valid[m]), 32'd0);
            chk("rst_pc", o_pc[m], 32'd0);
            chk("rst_insn", o_insn[m], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Overflow: 7 retirements into 4 slots, no reads
        trig_en = 1'b0;
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) retire(32'h100 + 32'(4 * i));
        chk("ovf_cnt_stop", 32'(o_count[0]), 32'd4);
        chk("ovf_drop_stop", 32'(o_drop[0]), 32'd3);
        chk("ovf_cnt_wrap", 32'(o_count[1]), 32'd4);
        chk("ovf_drop_wrap", 32'(o_drop[1]), 32'd3);
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("pop_stop_pc", o_pc[0], 32'h100 + 32'(4 * i));
            chk("pop_wrap_pc", o_pc[1], 32'h10C + 32'(4 * i));
            cyc();
        end
        chk("empty_stop", 32'(o_valid[0]), 32'd0);
        chk("empty_wrap", 32'(o_valid[1]), 32'd0);
        rd_ready = 1'b0;
        pulse(1'b0, 1'b1, 1'b0);

        // PC trigger
        pulse(1'b0, 1'b0, 1'b1);
        trig_en = 1'b1;
        trig_pc = 32'h208;
        pulse(1'b1, 1'b0, 1'b0);
        chk("trig_armed", 32'(o_state[0]), 32'd1);
        retire(32'h200);
        retire(32'h204);
        chk("trig_wait", 32'(o_state[0]), 32'd1);
        retire(32'h208);
        chk("trig_fire", 32'(o_state[0]), 32'd2);
        chk("trig_first", o_pc[0], 32'h208);
        retire(32'h20C);
        chk("trig_cnt", 32'(o_count[1]), 32'd2);
        rd_ready = 1'b1;
        cyc();
        chk("trig_second", o_pc[0], 32'h20C);
        cyc();
        rd_ready = 1'b0;

        // Full buffer streaming with simultaneous pop and write
        pulse(1'b0, 1'b0, 1'b1);
        trig_en = 1'b0;
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) retire(32'h400 + 32'(4 * i));
        rd_ready = 1'b1;
        for (int i = 4; i < 12; i++) begin
            chk("stream_pc", o_pc[0], 32'h400 + 32'(4 * (i - 4)));
            retire(32'h400 + 32'(4 * i));
            chk("stream_cnt", 32'(o_count[0]), 32'd4);
            chk("stream_drop", 32'(o_drop[1]), 32'd0);
        end
        rd_ready = 1'b0;

        // Stop coinciding with a retirement, then re-arm
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        retire(32'h280);
        retire(32'h284);
        stop = 1'b1;
        retire(32'h300);
        stop = 1'b0;
        chk("stop_idle", 32'(o_state[0]), 32'd0);
        chk("stop_cnt", 32'(o_count[0]), 32'd2);
        pulse(1'b1, 1'b0, 1'b0);
        chk("rearm_cap", 32'(o_state[1]), 32'd2);
        chk("kept_pc", o_pc[1], 32'h280);

        // Clear racing a pop
        retire(32'h500);
        chk("pre_clr_cnt", 32'(o_count[0]), 32'd3);
        rd_ready = 1'b1;
        pulse(1'b0, 1'b0, 1'b1);
        rd_ready = 1'b0;
        chk("clr_cnt", 32'(o_count[0]), 32'd0);
        chk("clr_state", 32'(o_state[0]), 32'd0);

        // Asynchronous reset mid-capture
        pulse(1'b1, 1'b0, 1'b0);
        retire(32'h600);
        retire(32'h604);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int m = 0; m < 2; m++) begin
            chk("arst_cnt", 32'(o_count[m]), 32'd0);
            chk("arst_state", 32'(o_state[m]), 32'd0);
            chk("arst_valid", 32'(o_valid[m]), 32'd0);
            chk("arst_pc", o_pc[m], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Randomized traffic
        trig_pc = 32'h70C;
        for (int i = 0; i < 500; i++) begin
            valid    = ($urandom_range(9) < 6);
            pc       = 32'h700 + 32'(4 * $urandom_range(7));
            insn     = $urandom;
            wdata    = $urandom;
            rd_addr  = 5'($urandom);
            trap     = 1'($urandom);
            intr     = 1'($urandom);
            arm      = ($urandom_range(11) == 0);
            stop     = ($urandom_range(29) == 0);
            clear    = ($urandom_range(59) == 0);
            trig_en  = 1'($urandom);
            rd_ready = ($urandom_range(9) < 4);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
